// File: rtl/tdd_pattern_gen_if.sv
// Configuration/status bundle between the ARM-side registers (master) and tdd_pattern_gen (slave).
// Defining TDD_PATTERN_IRQ_EN adds the i_irq_clr / o_irq pair.
interface tdd_pattern_gen_if #(
  parameter int CNT_W = 16,
  parameter int FRM_W = 16
);
  logic             i_start;
  logic             i_stop;
  logic [CNT_W-1:0] i_tx_len;
  logic [CNT_W-1:0] i_gap_tr;
  logic [CNT_W-1:0] i_rx_len;
  logic [CNT_W-1:0] i_gap_rt;
  logic [FRM_W-1:0] i_num_frames;
  logic             o_Tx_en;
  logic             o_Rx_en;
  logic             o_busy;
  logic             o_frame_done;
  logic [FRM_W-1:0] o_frame_cnt;
`ifdef TDD_PATTERN_IRQ_EN
  logic             i_irq_clr;
  logic             o_irq;

  modport master (
    output i_start, i_stop, i_tx_len, i_gap_tr, i_rx_len, i_gap_rt, i_num_frames, i_irq_clr,
    input  o_Tx_en, o_Rx_en, o_busy, o_frame_done, o_frame_cnt, o_irq
  );
  modport slave (
    input  i_start, i_stop, i_tx_len, i_gap_tr, i_rx_len, i_gap_rt, i_num_frames, i_irq_clr,
    output o_Tx_en, o_Rx_en, o_busy, o_frame_done, o_frame_cnt, o_irq
  );
`else
  modport master (
    output i_start, i_stop, i_tx_len, i_gap_tr, i_rx_len, i_gap_rt, i_num_frames,
    input  o_Tx_en, o_Rx_en, o_busy, o_frame_done, o_frame_cnt
  );
  modport slave (
    input  i_start, i_stop, i_tx_len, i_gap_tr, i_rx_len, i_gap_rt, i_num_frames,
    output o_Tx_en, o_Rx_en, o_busy, o_frame_done, o_frame_cnt
  );
`endif
endinterface

// File: rtl/tdd_pattern_gen.sv
// TDD frame schedule generator: TX, TX->RX guard, RX, RX->TX guard, repeated per frame.
// Optional macro TDD_PATTERN_IRQ_EN adds a sticky end-of-run interrupt.
module tdd_pattern_gen #(
  parameter int CNT_W = 16,
  parameter int FRM_W = 16
) (
  input logic              clk_in,
  input logic              rst_n,
  tdd_pattern_gen_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TX     = 3'd1;
  localparam logic [2:0] GAP_TR = 3'd2;
  localparam logic [2:0] RX     = 3'd3;
  localparam logic [2:0] GAP_RT = 3'd4;

  // Phase i (0..3) maps to state i+1; lengths are packed with phase 0 in the low slice.
  function automatic logic [2:0] first_phase(input logic [4*CNT_W-1:0] lens, input int from);
    first_phase = IDLE;
    for (int i = 3; i >= 0; i--)
      if (i >= from && lens[i*CNT_W +: CNT_W] != '0) first_phase = 3'(i + 1);
  endfunction

  function automatic logic [CNT_W-1:0] phase_load(input logic [4*CNT_W-1:0] lens, input logic [2:0] st);
    phase_load = '0;
    if (st != IDLE) phase_load = lens[(int'(st) - 1)*CNT_W +: CNT_W] - CNT_W'(1);
  endfunction

  logic [4*CNT_W-1:0] lens_in, lens_q;
  logic [FRM_W-1:0]   num_q, frame_cnt, frame_cnt_nx, frame_inc;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         state, state_nx;
  logic               stop_pend, stop_nx, done_nx, load;
  logic               tx_en, rx_en, busy, frame_done;

  assign lens_in   = {bus.i_gap_rt, bus.i_rx_len, bus.i_gap_tr, bus.i_tx_len};
  assign frame_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + FRM_W'(1);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    stop_nx      = stop_pend;
    frame_cnt_nx = frame_cnt;
    done_nx      = 1'b0;
    load         = 1'b0;
    if (state == IDLE) begin
      if (bus.i_start && (bus.i_tx_len != '0 || bus.i_rx_len != '0)) begin
        load         = 1'b1;
        frame_cnt_nx = '0;
        state_nx     = first_phase(lens_in, 0);
        cnt_nx       = phase_load(lens_in, state_nx);
      end
    end else begin
      if (bus.i_stop) stop_nx = 1'b1;
      if (cnt != '0) begin
        cnt_nx = cnt - CNT_W'(1);
      end else begin
        state_nx = first_phase(lens_q, int'(state));
        // No later non-zero phase means this was the last active cycle of the frame.
        if (state_nx == IDLE) begin
          done_nx      = 1'b1;
          frame_cnt_nx = frame_inc;
          if (!((num_q != '0 && frame_inc == num_q) || stop_pend || bus.i_stop))
            state_nx = first_phase(lens_q, 0);
        end
        cnt_nx = phase_load(lens_q, state_nx);
      end
      if (state_nx == IDLE) stop_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lens_q     <= '0;
      num_q      <= '0;
      stop_pend  <= 1'b0;
      frame_cnt  <= '0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      stop_pend  <= stop_nx;
      frame_cnt  <= frame_cnt_nx;
      tx_en      <= (state_nx == TX);
      rx_en      <= (state_nx == RX);
      busy       <= (state_nx != IDLE);
      frame_done <= done_nx;
      if (load) begin
        lens_q <= lens_in;
        num_q  <= bus.i_num_frames;
      end
    end
  end

  assign bus.o_Tx_en      = tx_en;
  assign bus.o_Rx_en      = rx_en;
  assign bus.o_busy       = busy;
  assign bus.o_frame_done = frame_done;
  assign bus.o_frame_cnt  = frame_cnt;

`ifdef TDD_PATTERN_IRQ_EN
  logic irq;

  // Set has priority over clear so a run end is never lost.
  always_ff @(posedge clk_in) begin
    if (!rst_n)                                irq <= 1'b0;
    else if (state != IDLE && state_nx == IDLE) irq <= 1'b1;
    else if (bus.i_irq_clr)                     irq <= 1'b0;
  end

  assign bus.o_irq = irq;
`endif

endmodule

// File: tb/tb_tdd_pattern_gen.sv
// Scoreboard bench for tdd_pattern_gen: frame_done events checked by a monitor, windows per cycle.
module tb_tdd_pattern_gen;
  localparam int CNT_W = 16;
  localparam int FRM_W = 16;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  tdd_pattern_gen_if #(.CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();

  tdd_pattern_gen #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int rel;
    int cnt;
  } done_t;

  done_t sb[$];
  int    cyc    = 0;
  int    t0     = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, actual, expected, cyc - t0);
    end
  endtask

  // Monitor: every frame_done pulse must match the next queued expectation.
  always @(negedge clk_in) begin
    done_t e;
    if (bus.o_frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done_cycle", 32'(cyc - t0), 32'(e.rel));
        checkOutput("done_cnt", 32'(bus.o_frame_cnt), 32'(e.cnt));
      end
    end
  end

  // Hand-derived windows per scenario kind, in cycles relative to the start cycle.
  function automatic logic expTx(input int kind, input int r);
    case (kind)
      0, 2:    return (r >= 1 && r <= 4) || (r >= 11 && r <= 14);
      1:       return (r >= 1 && r <= 3);
      3, 4:    return (r >= 1 && r <= 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic expRx(input int kind, input int r);
    case (kind)
      0, 2:    return (r >= 7 && r <= 9) || (r >= 17 && r <= 19);
      1:       return (r >= 4 && r <= 5);
      3:       return (r >= 7 && r <= 8);
      4:       return (r >= 7 && r <= 9);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic expBusy(input int kind, input int r);
    case (kind)
      0, 2:    return (r >= 1 && r <= 20);
      1:       return (r >= 1 && r <= 5);
      3:       return (r >= 1 && r <= 8);
      4:       return (r >= 1 && r <= 10);
      default: return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input int kind, input int tx, input int gtr, input int rx, input int grt,
                               input int frames, input logic with_stop, input int stop_at,
                               input int rst_at, input int ncyc, input int exp_cnt, input logic chk_irq);
    @(negedge clk_in);
    bus.i_tx_len     = CNT_W'(tx);
    bus.i_gap_tr     = CNT_W'(gtr);
    bus.i_rx_len     = CNT_W'(rx);
    bus.i_gap_rt     = CNT_W'(grt);
    bus.i_num_frames = FRM_W'(frames);
    bus.i_start      = 1'b1;
    bus.i_stop       = with_stop;
`ifdef TDD_PATTERN_IRQ_EN
    bus.i_irq_clr    = 1'b1;
`endif
    t0 = cyc;
    for (int r = 1; r <= ncyc; r++) begin
      @(negedge clk_in);
      rst_n        = 1'b1;
      bus.i_start  = 1'b0;
      bus.i_stop   = 1'b0;
      // Scramble the live inputs; the run must keep using the latched copies.
      bus.i_tx_len     = CNT_W'(1);
      bus.i_gap_tr     = CNT_W'(5);
      bus.i_rx_len     = CNT_W'(1);
      bus.i_gap_rt     = CNT_W'(0);
      bus.i_num_frames = FRM_W'(1);
`ifdef TDD_PATTERN_IRQ_EN
      bus.i_irq_clr = (r == 25);
      if (chk_irq) checkOutput("irq", 32'(bus.o_irq), 32'(r >= 21 && r <= 25));
`endif
      checkOutput("tx_en", 32'(bus.o_Tx_en), 32'(expTx(kind, r)));
      checkOutput("rx_en", 32'(bus.o_Rx_en), 32'(expRx(kind, r)));
      checkOutput("busy", 32'(bus.o_busy), 32'(expBusy(kind, r)));
      if (kind == 3 && r == 9) checkOutput("cnt_after_rst", 32'(bus.o_frame_cnt), 32'd0);
      if (r == stop_at) bus.i_stop = 1'b1;
      if (r == rst_at) rst_n = 1'b0;
    end
    checkOutput("frame_cnt_end", 32'(bus.o_frame_cnt), 32'(exp_cnt));
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_tx_len     = '0;
    bus.i_gap_tr     = '0;
    bus.i_rx_len     = '0;
    bus.i_gap_rt     = '0;
    bus.i_num_frames = '0;
`ifdef TDD_PATTERN_IRQ_EN
    bus.i_irq_clr    = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    checkOutput("rst_tx", 32'(bus.o_Tx_en), 32'd0);
    checkOutput("rst_rx", 32'(bus.o_Rx_en), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.o_frame_done), 32'd0);
    checkOutput("rst_cnt", 32'(bus.o_frame_cnt), 32'd0);
`ifdef TDD_PATTERN_IRQ_EN
    checkOutput("rst_irq", 32'(bus.o_irq), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk_in);
    bus.i_stop = 1'b1;
    @(negedge clk_in);
    bus.i_stop = 1'b0;
    checkOutput("idle_stop_busy", 32'(bus.o_busy), 32'd0);

    $display("[TB] basic run");
    sb.push_back('{rel: 11, cnt: 1});
    sb.push_back('{rel: 21, cnt: 2});
    applyStimulus(0, 4, 2, 3, 1, 2, 1'b0, -1, -1, 27, 2, 1'b1);

    $display("[TB] zero-length gaps");
    sb.push_back('{rel: 6, cnt: 1});
    applyStimulus(1, 3, 0, 2, 0, 1, 1'b0, -1, -1, 9, 1, 1'b0);

    $display("[TB] graceful stop mid-frame");
    sb.push_back('{rel: 11, cnt: 1});
    sb.push_back('{rel: 21, cnt: 2});
    applyStimulus(2, 4, 2, 3, 1, 0, 1'b0, 13, -1, 24, 2, 1'b0);

    $display("[TB] stop on the frame-end cycle");
    sb.push_back('{rel: 11, cnt: 1});
    applyStimulus(4, 4, 2, 3, 1, 0, 1'b0, 10, -1, 14, 1, 1'b0);

    $display("[TB] start and stop together");
    sb.push_back('{rel: 11, cnt: 1});
    sb.push_back('{rel: 21, cnt: 2});
    applyStimulus(0, 4, 2, 3, 1, 2, 1'b1, -1, -1, 24, 2, 1'b0);

    $display("[TB] reset mid-RX");
    applyStimulus(3, 4, 2, 3, 1, 2, 1'b0, -1, 8, 14, 0, 1'b0);

    $display("[TB] illegal start");
    applyStimulus(5, 0, 2, 0, 1, 1, 1'b0, -1, -1, 6, 0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not finish");
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
